lsu_handshake: RTL and testbench
================================

# lsu_handshake

Load/store unit between the RV32I execute stage (ALU address, rs2 store data, funct3) and a data memory with a valid/ready handshake. It replaces the single-cycle combinational data-memory access with a multi-cycle bus transaction. It stalls the core until the transaction completes. It handles byte and halfword lane alignment, write strobes, load sign/zero extension and misalignment detection.

## Interface
- `ADDR_W`, default 32: address width of `req_addr` and `mem_addr`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: the current instruction is a load or store.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: instruction funct3, which gives size and signedness.
- `req_addr` in ADDR_W: byte address from the ALU.
- `req_wdata` in 32: rs2 value.
- `stall` out 1: hold PC and register-file write.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `err` out 1: one-cycle pulse, coincident with `rsp_valid`, on an illegal or misaligned access.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: the memory accepts or completes the request.
- `mem_we` out 1: bus write enable.
- `mem_addr` out ADDR_W: word-aligned address; bits [1:0] are always 0.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_wstrb` out 4: byte write strobes; 0 on reads.
- `mem_rdata` in 32: read word, sampled when `mem_valid && mem_ready`.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- **IDLE, `req_valid`=1, legal access:**
  - Latch we, funct3, addr and wdata.
  - Next state is BUSY.
- **IDLE, `req_valid`=1, error:**
  - Latch the request.
  - Next state is RESP with the error flag set.
  - No bus transaction is issued.
- **BUSY:**
  - `mem_valid`=1; all `mem_*` outputs are stable until `mem_ready`=1.
  - On the handshake, capture `mem_rdata` and go to RESP.
- **RESP:**
  - `rsp_valid`=1 for exactly one cycle, then return to IDLE.
  - `req_valid` is ignored in RESP.
- `stall` = (IDLE && `req_valid`) || BUSY. It is 0 in RESP.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is illegal and sets `err`.
- Misaligned accesses:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
- Store data and strobes:
  - SB: `mem_wdata`={4{b[7:0]}}, `mem_wstrb`=0001<<addr[1:0].
  - SH: `mem_wdata`={2{b[15:0]}}, `mem_wstrb`=0011<<{addr[1],1'b0}.
  - SW: `mem_wstrb`=1111.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.

## Timing
- All outputs are 0 in reset. The FSM is in IDLE. `mem_valid` drops asynchronously on reset assertion.
- Reset mid-BUSY aborts the transaction. No `rsp_valid` is produced.
- Latency from request to `rsp_valid`:
  - Minimum 2 cycles after the request cycle: request in cycle 0, BUSY in cycle 1 with `mem_ready`=1, RESP in cycle 2.
  - Each cycle of `mem_ready`=0 adds one cycle.
- Error path: RESP is reached in cycle 1.
- `mem_ready` outside BUSY is ignored.
- Back-to-back requests: the next request is accepted in the cycle after RESP. There is at least one idle cycle between bus transactions.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses take the error path.
  - `err`=1, `rsp_rdata`=0, no bus transaction.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned halfword addresses are treated as addr[0]=0.
  - Misaligned word addresses are treated as addr[1:0]=00.
  - The access then proceeds normally with `err`=0.
- Illegal funct3 sets `err` in both builds.

## Test plan
- **LB, sign-extended:** addr 0x103, `mem_rdata` 0x80FF_0000 → `mem_addr` 0x100, `rsp_rdata` 0xFFFF_FF80, `stall` high for 2 cycles.
- **LHU, with wait states:** addr 0x202, `mem_rdata` 0xBEEF_1234, `mem_ready` low for 3 cycles → `rsp_rdata` 0x0000_BEEF. `rsp_valid` appears 5 cycles after the request. `mem_*` outputs stay stable while waiting.
- **SB:** addr 0x11, data 0x0000_00A5 → `mem_wstrb` 0010, `mem_wdata` 0xA5A5_A5A5, `mem_addr` 0x10, `rsp_rdata` 0.
- **SW misaligned, addr 0x06:**
  - With the macro: no `mem_valid`, `err` and `rsp_valid` in cycle 1.
  - Without the macro: `mem_addr` 0x04, `mem_wstrb` 1111, `err`=0.
- **Illegal load funct3 011:** `err`=1, `rsp_valid`=1, no bus transaction (both builds).
- **Reset asserted during BUSY:** `mem_valid` falls immediately, `stall`=0, no `rsp_valid`. After release, an LW at 0x0 completes normally.

Source files
------------

// File: rtl/lsu_handshake.sv
// lsu_handshake: RV32I load/store unit driving a valid/ready data-memory bus.
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_handshake #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        f3_ok;
  logic        bad;
  logic [1:0]  lane;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] sh;
  logic [31:0] ldata;

  always_comb begin
    f3_ok = 1'b0;
    bad   = 1'b0;
    lane  = req_addr[1:0];
    wdata = req_wdata;
    wstrb = 4'b0000;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we;
      default:                f3_ok = 1'b0;
    endcase
    // Lane is the effective (possibly force-aligned) byte offset.
    unique case (req_funct3[1:0])
      2'b00: begin
        wdata = {4{req_wdata[7:0]}};
        wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        lane  = {req_addr[1], 1'b0};
        wdata = {2{req_wdata[15:0]}};
        wstrb = 4'b0011 << lane;
`ifdef LSU_MISALIGN_TRAP_EN
        bad   = req_addr[0];
`endif
      end
      2'b10: begin
        lane  = 2'b00;
        wstrb = 4'b1111;
`ifdef LSU_MISALIGN_TRAP_EN
        bad   = |req_addr[1:0];
`endif
      end
      default: ;
    endcase
    if (!req_we) wstrb = 4'b0000;
    bad = bad || !f3_ok;
  end

  assign sh = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    ldata = sh;
    unique case (f3_q)
      3'b000:  ldata = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ldata = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ldata = {24'h0, sh[7:0]};
      3'b101:  ldata = {16'h0, sh[15:0]};
      default: ldata = sh;
    endcase
  end

  assign stall = reset &&
    ((state == IDLE && req_valid) || state == BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      f3_q      <= 3'b000;
      lane_q    <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      err       <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          f3_q   <= req_funct3;
          lane_q <= lane;
          if (bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            err       <= 1'b1;
            rsp_rdata <= 32'h0;
          end else begin
            state     <= BUSY;
            mem_valid <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata;
            mem_wstrb <= wstrb;
          end
        end
        BUSY: if (mem_ready) begin
          state     <= RESP;
          mem_valid <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_we ? 32'h0 : ldata;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          err       <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_handshake.sv
// tb_lsu_handshake: directed table, reset corner case and random
// transactions against a byte-level reference model of the LSU.
module tb_lsu_handshake;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_handshake #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .err        (err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        waits;
    bit        err;
    bit [31:0] rdata_x;
    bit [31:0] maddr_x;
    bit [3:0]  wstrb_x;
    bit [31:0] wdata_x;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: accesses as byte ranges of size 1, 2 or 4 bytes.
  function automatic vec_t model(input vec_t v);
    vec_t            r;
    int              size;
    int              off;
    bit              legal;
    bit              mis;
    bit [31:0]       ea;
    longint unsigned val;
    longint unsigned mask;
    r     = v;
    legal = v.we ? (v.f3 <= 3'd2) : (v.f3 inside {0, 1, 2, 4, 5});
    size  = 1 << v.f3[1:0];
    mis   = legal && ((v.addr % size) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    r.err = !legal || mis;
`else
    r.err = !legal;
`endif
    r.rdata_x = 0;
    r.maddr_x = 0;
    r.wstrb_x = 0;
    r.wdata_x = 0;
    if (!r.err) begin
      ea        = v.addr - (v.addr % size);
      r.maddr_x = ea & ~32'h3;
      off       = int'(ea % 4);
      if (v.we) begin
        r.wstrb_x = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++)
          r.wdata_x[8*i +: 8] = v.wdata[8*(i % size) +: 8];
      end else begin
        mask = (64'd1 << (8 * size)) - 1;
        val  = (64'(v.rdata) >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
        r.rdata_x = val[31:0];
      end
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge
  // of the cycle following RESP, so calls chain back-to-back.
  task automatic txn(input string tag, input vec_t v, input bit early);
    int c;
    int w;
    bit bus;
    bit done;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_ready  = early;
    mem_rdata  = $urandom;
    #1 chk({tag, ".stall_req"}, stall, 1);
    c    = 0;
    w    = 0;
    bus  = 0;
    done = 0;
    while (!done && c < 64) begin
      @(negedge clk);
      c++;
      if (rsp_valid) begin
        done = 1;
        chk({tag, ".lat"}, c, v.err ? 1 : 2 + v.waits);
        chk({tag, ".err"}, err, v.err);
        chk({tag, ".rdata"}, rsp_rdata, v.rdata_x);
        chk({tag, ".stall_resp"}, stall, 0);
        chk({tag, ".mv_resp"}, mem_valid, 0);
        chk({tag, ".bus"}, bus, !v.err);
      end else if (mem_valid) begin
        bus = 1;
        chk({tag, ".stall_busy"}, stall, 1);
        chk({tag, ".maddr"}, mem_addr, v.maddr_x);
        chk({tag, ".mwe"}, mem_we, v.we);
        chk({tag, ".wstrb"}, mem_wstrb, v.wstrb_x);
        if (v.we) chk({tag, ".wdata"}, mem_wdata, v.wdata_x);
        if (w == v.waits) begin
          mem_ready = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          w++;
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout: got no rsp_valid expected one", tag);
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".pulse"}, rsp_valid, 0);
    chk({tag, ".err_pulse"}, err, 0);
    chk({tag, ".idle_mv"}, mem_valid, 0);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b1;
    mem_rdata  = 32'h0;

    // we f3 addr wdata rdata waits | err rdata maddr wstrb wdata
    tbl.push_back('{0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0,
                    0, 32'hFFFF_FF80, 32'h100, 4'h0, 32'h0});
    tbl.push_back('{0, 3'b101, 32'h202, 32'h0, 32'hBEEF_1234, 3,
                    0, 32'h0000_BEEF, 32'h200, 4'h0, 32'h0});
    tbl.push_back('{1, 3'b000, 32'h11, 32'h0000_00A5, 32'h0, 0,
                    0, 32'h0, 32'h10, 4'b0010, 32'hA5A5_A5A5});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{1, 3'b010, 32'h06, 32'h1234_5678, 32'h0, 0,
                    1, 32'h0, 32'h0, 4'h0, 32'h0});
`else
    tbl.push_back('{1, 3'b010, 32'h06, 32'h1234_5678, 32'h0, 0,
                    0, 32'h0, 32'h04, 4'b1111, 32'h1234_5678});
`endif
    tbl.push_back('{0, 3'b011, 32'h40, 32'h0, 32'h0, 0,
                    1, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 0,
                    0, 32'hFFFF_8001, 32'h100, 4'h0, 32'h0});
    tbl.push_back('{0, 3'b100, 32'h101, 32'h0, 32'h1234_80FF, 2,
                    0, 32'h0000_0080, 32'h100, 4'h0, 32'h0});
    tbl.push_back('{0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1,
                    0, 32'hDEAD_BEEF, 32'h8, 4'h0, 32'h0});
    tbl.push_back('{1, 3'b001, 32'h22, 32'hFFFF_C3D2, 32'h0, 0,
                    0, 32'h0, 32'h20, 4'b1100, 32'hC3D2_C3D2});
    tbl.push_back('{1, 3'b100, 32'h30, 32'h1, 32'h0, 0,
                    1, 32'h0, 32'h0, 4'h0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{0, 3'b001, 32'h103, 32'h0, 32'h8001_7FFF, 0,
                    1, 32'h0, 32'h0, 4'h0, 32'h0});
`else
    tbl.push_back('{0, 3'b001, 32'h103, 32'h0, 32'h8001_7FFF, 0,
                    0, 32'hFFFF_8001, 32'h100, 4'h0, 32'h0});
`endif

    // Reset state, with a pending request that must not raise stall.
    repeat (2) @(negedge clk);
    chk("rst.stall", stall, 0);
    chk("rst.mem_valid", mem_valid, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.err", err, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wstrb", {28'h0, mem_wstrb}, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    req_valid = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) txn($sformatf("vec%0d", i), tbl[i], i[0]);

    // Reset asserted mid-BUSY aborts the bus transaction.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    mem_ready  = 1'b0;
    @(negedge clk);
    chk("abort.busy", mem_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort.mem_valid", mem_valid, 0);
    chk("abort.stall", stall, 0);
    chk("abort.rsp_valid", rsp_valid, 0);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort.no_rsp", rsp_valid, 0);
      chk("abort.no_bus", mem_valid, 0);
    end
    reset     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("abort.after_rsp", rsp_valid, 0);
    chk("abort.after_stall", stall, 0);
    v = '{0, 3'b010, 32'h0, 32'h0, 32'h1357_9BDF, 0,
          0, 32'h1357_9BDF, 32'h0, 4'h0, 32'h0};
    txn("abort.lw", v, 1'b0);

    for (int n = 0; n < 200; n++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom & 32'h0000_0FFF;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.waits = $urandom_range(0, 3);
      v       = model(v);
      txn($sformatf("rnd%0d", n), v, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected one");
    $fatal(1);
  end

endmodule
